// File: rtl/dbghost.sv
// Host-side initiator for the chipset debug link: shifts a select/payload
// command out MSB-first and captures the controller's framed 16-bit reply.
module dbghost #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_sel,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic [2:0]  sel,
  output logic        dbg_out,
  input  logic        dbg_in
);

  localparam logic [16:0] TIMEOUT_CMP = 17'(TIMEOUT);
  localparam logic [15:0] TIMEOUT_SAT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_RECV  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  sel_lat_q, sel_lat_d;
  logic [15:0] data_lat_q, data_lat_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] shift_q, shift_d;
  logic        to_flag_q, to_flag_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [2:0]  sel_q, sel_d;
  logic        dbg_out_q, dbg_out_d;
  logic [16:0] tcnt_inc_s;

  assign tcnt_inc_s = {1'b0, tcnt_q} + 17'd1;

  // Next-state logic and the registered-output values for the upcoming cycle
  always_comb begin
    state_d    = state_q;
    sel_lat_d  = sel_lat_q;
    data_lat_d = data_lat_q;
    bcnt_d     = bcnt_q;
    tcnt_d     = tcnt_q;
    shift_d    = shift_q;
    to_flag_d  = to_flag_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          sel_lat_d  = req_sel;
          data_lat_d = req_data;
          bcnt_d     = 4'd0;
          if (req_sel != 3'd0) begin
            state_d = S_LEAD;
          end else begin
            state_d   = S_DONE;
            to_flag_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEAD: begin
        state_d = S_SHIFT;
        bcnt_d  = 4'd0;
      end
      S_SHIFT: begin
        if (bcnt_q == 4'd15) begin
          state_d = S_WAIT;
          bcnt_d  = 4'd0;
          tcnt_d  = 16'd0;
        end else begin
          bcnt_d = bcnt_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (dbg_in) begin
          state_d = S_RECV;
          bcnt_d  = 4'd0;
        end else if (tcnt_inc_s >= TIMEOUT_CMP) begin
          state_d   = S_DONE;
          to_flag_d = 1'b1;
          tcnt_d    = TIMEOUT_SAT;
        end else begin
          tcnt_d = tcnt_inc_s[15:0];
        end
      end
      S_RECV: begin
        shift_d = {shift_q[14:0], dbg_in};
        if (bcnt_q == 4'd15) begin
          state_d   = S_DONE;
          to_flag_d = 1'b0;
          bcnt_d    = 4'd0;
        end else begin
          bcnt_d = bcnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they register with it
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
    if (rsp_valid_d) begin
      rsp_data_d    = to_flag_d ? 16'd0 : shift_d;
      rsp_timeout_d = to_flag_d;
    end else begin
      rsp_data_d    = rsp_data_q;
      rsp_timeout_d = rsp_timeout_q;
    end

    // Select drops on the last shift bit so the controller latches exactly 16
    if ((state_d == S_LEAD) || ((state_d == S_SHIFT) && (bcnt_d != 4'd15))) begin
      sel_d = sel_lat_d;
    end else begin
      sel_d = 3'd0;
    end

    if (state_d == S_SHIFT) begin
      dbg_out_d = data_lat_d[4'd15 - bcnt_d];
    end else begin
      dbg_out_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sel_lat_q     <= 3'd0;
      data_lat_q    <= 16'd0;
      bcnt_q        <= 4'd0;
      tcnt_q        <= 16'd0;
      shift_q       <= 16'd0;
      to_flag_q     <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 16'd0;
      rsp_timeout_q <= 1'b0;
      sel_q         <= 3'd0;
      dbg_out_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_lat_q     <= sel_lat_d;
      data_lat_q    <= data_lat_d;
      bcnt_q        <= bcnt_d;
      tcnt_q        <= tcnt_d;
      shift_q       <= shift_d;
      to_flag_q     <= to_flag_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      sel_q         <= sel_d;
      dbg_out_q     <= dbg_out_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign sel         = sel_q;
  assign dbg_out     = dbg_out_q;

endmodule

// File: tb/tb_dbghost.sv
// Randomized self-checking bench for dbghost; expectations come from a
// cycle-numbered model of the command/response timeline.
module tb_dbghost;

  localparam int TMO = 8;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_sel;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_timeout;
  logic [2:0]  sel;
  logic        dbg_out;
  logic        dbg_in;

  int n_checks;
  int n_errors;
  logic [15:0] exp_rsp_data;
  logic        exp_rsp_to;

  dbghost #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sel    (req_sel),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_timeout(rsp_timeout),
    .sel        (sel),
    .dbg_out    (dbg_out),
    .dbg_in     (dbg_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_rvalid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rdata"}, 32'(rsp_data), 32'd0);
    check_eq({tag, "_rto"}, 32'(rsp_timeout), 32'd0);
    check_eq({tag, "_sel"}, 32'(sel), 32'd0);
    check_eq({tag, "_dout"}, 32'(dbg_out), 32'd0);
  endtask

  // Entered and left at a negedge with the DUT idle. dly = start-bit delay
  // after WAIT entry (>= TMO means no start bit). rst_at > 0 aborts with reset.
  task automatic run_cmd(input logic [2:0] s, input logic [15:0] d, input int dly,
                         input logic [15:0] resp, input bit hold, input int rst_at);
    int w;
    int r;
    bit to;
    int idx;
    logic [2:0] esel;
    logic       eout;
    check_eq("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_sel   = s;
    req_data  = d;
    dbg_in    = 1'($urandom);
    w = 1 << 20;
    if (s == 3'd0) begin
      r = 1;  to = 1'b1;
    end else if (dly < TMO) begin
      w = 18 + dly;  r = w + 17;  to = 1'b0;
    end else begin
      r = 18 + TMO;  to = 1'b1;
    end
    for (int k = 1; k <= r + 1; k++) begin
      @(negedge clk);
      if (rst_at > 0 && k == rst_at + 1) begin
        check_reset_vals($sformatf("midrst_c%0d", k));
        exp_rsp_data = 16'd0;
        exp_rsp_to   = 1'b0;
        rst_n = 1'b1;
        return;
      end
      esel = (s != 3'd0 && k <= 16) ? s : 3'd0;
      eout = 1'b0;
      if (s != 3'd0 && k >= 2 && k <= 17) eout = d[17 - k];
      if (k == r) begin
        exp_rsp_data = to ? 16'd0 : resp;
        exp_rsp_to   = to;
      end
      check_eq($sformatf("sel_c%0d", k), 32'(sel), 32'(esel));
      check_eq($sformatf("dout_c%0d", k), 32'(dbg_out), 32'(eout));
      check_eq($sformatf("rvalid_c%0d", k), 32'(rsp_valid), 32'(k == r));
      check_eq($sformatf("ready_c%0d", k), 32'(req_ready), 32'(k == r + 1));
      if (k >= r) begin
        check_eq($sformatf("rdata_c%0d", k), 32'(rsp_data), 32'(exp_rsp_data));
        check_eq($sformatf("rto_c%0d", k), 32'(rsp_timeout), 32'(exp_rsp_to));
      end
      req_valid = (k <= r) ? hold : 1'b0;
      if (hold) begin
        req_sel  = 3'($urandom);
        req_data = 16'($urandom);
      end
      if (rst_at > 0 && k == rst_at) begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
      end
      if (s != 3'd0 && k >= 18 && k < w && k < r) begin
        dbg_in = 1'b0;
      end else if (k == w) begin
        dbg_in = 1'b1;
      end else if (k > w && k <= w + 16) begin
        idx = 15 - (k - w - 1);
        dbg_in = resp[idx];
      end else begin
        dbg_in = 1'($urandom);
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    exp_rsp_data = 16'd0;
    exp_rsp_to   = 1'b0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_sel      = 3'd0;
    req_data     = 16'd0;
    dbg_in       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // PC command with reply 1234, start bit at cycle 20
    run_cmd(3'd1, 16'hA5C3, 2, 16'h1234, 1'b0, 0);
    // No start bit: timeout
    run_cmd(3'd1, 16'h0F0F, TMO, 16'h0000, 1'b0, 0);
    // Zero select completes at once
    run_cmd(3'd0, 16'hFFFF, 0, 16'h0000, 1'b0, 0);
    // Start bit on the first WAIT cycle, last usable WAIT cycle
    run_cmd(3'd7, 16'h8001, 0, 16'hBEEF, 1'b1, 0);
    run_cmd(3'd2, 16'h7FFE, TMO - 1, 16'hC0DE, 1'b0, 0);
    // Reset mid-SHIFT, then quiet cycles, then a normal command
    run_cmd(3'd1, 16'h5555, 3, 16'hAAAA, 1'b1, 8);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check_eq($sformatf("post_rst_quiet%0d", i), 32'(rsp_valid), 32'd0);
    end
    run_cmd(3'd3, 16'h1357, 1, 16'h2468, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [2:0] rs;
      rs = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      run_cmd(rs, 16'($urandom), int'($urandom_range(0, TMO + 2)), 16'($urandom),
              1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
